// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default qualification time for the button debouncer
package debounce_pkg;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 40000;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;
endpackage

// File: rtl/debounce_timer.sv
// debounce_timer: 16-bit qualification counter, cleared whenever the FSM is not waiting
import debounce_pkg::*;
module debounce_timer #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic timer_run,
    output logic timer_done
);
    logic [15:0] count;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else        count <= timer_run ? count + 16'd1 : '0;
    assign timer_done = count == 16'(DEBOUNCE_CYCLES - 1);
endmodule

// File: rtl/button_debounce_ctrl.sv
// button_debounce_ctrl: synchronizes a raw push-button, qualifies each edge for DEBOUNCE_CYCLES
// stable cycles and emits a registered level plus single-cycle press/release pulses
import debounce_pkg::*;
module button_debounce_ctrl #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic busy
);
    logic   sync1, btn_sync;
    state_t state, next;
    logic   timer_run, timer_done;
    logic   level_d, press_d, release_d;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {btn_sync, sync1} <= '0;
        else        {btn_sync, sync1} <= {sync1, btn_raw};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;
    // an input change inside a wait state wins over a coincident timer_done
    always_comb begin
        next = state;
        case (state)
            IDLE:         next = btn_sync ? PRESS_WAIT : IDLE;
            PRESS_WAIT:   next = !btn_sync ? IDLE : timer_done ? PRESSED : PRESS_WAIT;
            PRESSED:      next = !btn_sync ? RELEASE_WAIT : PRESSED;
            RELEASE_WAIT: next = btn_sync ? PRESSED : timer_done ? IDLE : RELEASE_WAIT;
            default:      next = IDLE;
        endcase
    end
    always_comb begin
        timer_run = state == PRESS_WAIT || state == RELEASE_WAIT;
        busy      = timer_run;
        press_d   = state == PRESS_WAIT && next == PRESSED;
        release_d = state == RELEASE_WAIT && next == IDLE;
        level_d   = next == PRESSED || next == RELEASE_WAIT;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {btn_level, btn_press, btn_release} <= '0;
        else        {btn_level, btn_press, btn_release} <= {level_d, press_d, release_d};
    debounce_timer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .timer_run (timer_run),
        .timer_done(timer_done)
    );
endmodule

// File: tb/tb_button_debounce_ctrl.sv
// tb_button_debounce_ctrl: directed and random stimulus against a streak-counting reference:
// the debounced level flips once the synchronized input has disagreed with it for N+1 samples
module tb_button_debounce_ctrl;
    localparam int N = 8;
    logic clk = 0, rst_n = 0, btn_raw = 0;
    logic btn_level, btn_press, btn_release, busy;
    int checks = 0, failures = 0;
    logic m1 = 0, m2 = 0, lvl = 0, e_press = 0, e_release = 0;
    int streak = 0, edge_n = 0, first_press = 0, first_rel = 0, npress = 0;

    button_debounce_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("level", btn_level, lvl);
        chk("press", btn_press, e_press);
        chk("release", btn_release, e_release);
        chk("busy", busy, streak > 0);
    endtask

    task automatic model_reset();
        m1 = 0; m2 = 0; lvl = 0; streak = 0; e_press = 0; e_release = 0;
    endtask

    task automatic step(input logic r);
        btn_raw = r;
        @(posedge clk);
        e_press = 0; e_release = 0;
        if (m2 != lvl) begin
            streak++;
            if (streak == N + 1) begin
                lvl = m2; streak = 0; e_press = m2; e_release = !m2;
            end
        end else streak = 0;
        m2 = m1; m1 = r; edge_n++;
        #1;
        if (btn_press) npress++;
        if (btn_press && first_press == 0) first_press = edge_n;
        if (btn_release && first_rel == 0) first_rel = edge_n;
        chk_all();
    endtask

    task automatic hold(input logic r, input int n);
        for (int i = 0; i < n; i++) step(r);
    endtask

    task automatic mark();
        edge_n = 0; first_press = 0; first_rel = 0; npress = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_all();
        @(negedge clk) rst_n = 1;

        mark(); hold(1, 20);
        chk_int("clean_press_edge", first_press, N + 3);
        chk_int("clean_press_count", npress, 1);

        mark(); hold(0, 20);
        chk_int("clean_release_edge", first_rel, N + 3);
        chk_int("clean_release_no_press", npress, 0);

        mark(); hold(1, 5); hold(0, 2);
        chk_int("bounce_burst_no_press", npress, 0);
        mark(); hold(1, 20);
        chk_int("bounce_press_edge", first_press, N + 3);
        chk_int("bounce_press_count", npress, 1);

        mark(); hold(0, 3); hold(1, 20);
        chk_int("glitch_no_release", first_rel, 0);
        chk_int("glitch_no_press", npress, 0);
        chk("glitch_level", btn_level, 1'b1);
        hold(0, 20);

        mark(); hold(1, N); hold(0, 12);
        chk_int("boundary_no_press", npress, 0);

        mark(); hold(1, 7);
        rst_n = 0;
        #1 model_reset();
        chk_all();
        chk("rst_level", btn_level, 1'b0);
        @(negedge clk) rst_n = 1;
        mark(); hold(1, 14);
        chk_int("post_reset_press_edge", first_press, N + 3);

        for (int k = 0; k < 150; k++) hold(k[0], $urandom_range(1, 12));
        hold(0, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
